interval_timer: RTL and testbench

Programmable 16-bit interval timer peripheral on the CPU's 16-bit register bus. It divides the system clock by a prescaler, counts down a reload value, and raises a level interrupt request on expiry. Its `irq` output drives one request input of the interrupt controller, which edge-detects it. It supports one-shot and periodic modes.

---
 rtl/interval_timer_pkg.sv | 29 ++
 rtl/timer_prescaler.sv | 29 ++
 rtl/interval_timer.sv | 91 +++++++++
 tb/tb_interval_timer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_pkg.sv
// Shared register map, control bit positions and helpers for the interval timer.
package interval_timer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RELOAD   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_COUNT    = 2'd3;

  localparam int unsigned CTL_EN       = 0;
  localparam int unsigned CTL_PERIODIC = 1;
  localparam int unsigned CTL_IRQ_EN   = 2;
  localparam int unsigned CTL_EXPIRED  = 15;

  // Assemble the CONTROL read value; unused bits read as zero.
  function automatic logic [DATA_W-1:0] ctl_word(input logic en, input logic periodic,
                                                 input logic irq_en, input logic expired);
    logic [DATA_W-1:0] w;
    w               = '0;
    w[CTL_EN]       = en;
    w[CTL_PERIODIC] = periodic;
    w[CTL_IRQ_EN]   = irq_en;
    w[CTL_EXPIRED]  = expired;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits one tick every (div+1) cycles while run is high.
module timer_prescaler
  import interval_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load,
  input  logic [DATA_W-1:0] div,
  output logic              tick
);

  logic [DATA_W-1:0] pre;

  // A tick on the load edge is still reported so the top can see a coincident expiry.
  assign tick = run & (pre == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (load) begin
      pre <= div;
    end else if (run) begin
      if (pre != '0) pre <= pre - DATA_W'(1);
      else           pre <= div;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// 16-bit programmable interval timer with one-shot/periodic modes and a level irq.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter logic [15:0] PRESCALE_RESET = 16'h0000,
  parameter logic [15:0] RELOAD_RESET   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] from_cpu,
  output logic [DATA_W-1:0] to_cpu,
  output logic              irq
);

  logic              en, periodic, irq_en, expired;
  logic [DATA_W-1:0] reload, prescale, counter;
  logic              wr, wr_ctl, run, tick, expire, start;
  logic [DATA_W-1:0] rd_data_c;

  assign wr     = ce & wren;
  assign wr_ctl = wr & (addr == ADDR_CONTROL);
  // Writing EN=0 freezes both counters on the very edge of the write.
  assign run    = en & ~(wr_ctl & ~from_cpu[CTL_EN]);
  assign expire = tick & (counter == '0);
  // An EN=1 write restarts from idle, or rescues a one-shot that expires on the same edge.
  assign start  = wr_ctl & from_cpu[CTL_EN] & (~en | (expire & ~periodic));

  timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .load (start),
    .div  (prescale),
    .tick (tick)
  );

  always_comb begin
    rd_data_c = '0;
    case (addr)
      ADDR_CONTROL:  rd_data_c = ctl_word(en, periodic, irq_en, expired);
      ADDR_RELOAD:   rd_data_c = reload;
      ADDR_PRESCALE: rd_data_c = prescale;
      ADDR_COUNT:    rd_data_c = counter;
      default:       rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      expired  <= 1'b0;
      reload   <= RELOAD_RESET;
      prescale <= PRESCALE_RESET;
      counter  <= '0;
      irq      <= 1'b0;
      to_cpu   <= '0;
    end else begin
      if (wr_ctl) begin
        en       <= from_cpu[CTL_EN];
        periodic <= from_cpu[CTL_PERIODIC];
        irq_en   <= from_cpu[CTL_IRQ_EN];
      end else if (expire & ~periodic) begin
        en <= 1'b0;
      end

      // Expiry beats a software clear on the same edge.
      if (expire)                             expired <= 1'b1;
      else if (wr_ctl & from_cpu[CTL_EXPIRED]) expired <= 1'b0;

      if (wr && addr == ADDR_RELOAD)   reload   <= from_cpu;
      if (wr && addr == ADDR_PRESCALE) prescale <= from_cpu;

      if (start) begin
        counter <= reload;
      end else if (tick) begin
        if (counter != '0) counter <= counter - DATA_W'(1);
        else if (periodic) counter <= reload;
      end

      irq <= irq_en & expired;

      if (ce) to_cpu <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer against an arithmetic timing model.
module tb_interval_timer;

  localparam logic [1:0] A_CTL = 2'd0;
  localparam logic [1:0] A_REL = 2'd1;
  localparam logic [1:0] A_PRE = 2'd2;
  localparam logic [1:0] A_CNT = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        wren;
  logic [1:0]  addr;
  logic [15:0] from_cpu;
  logic [15:0] to_cpu;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  interval_timer dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .wren     (wren),
    .addr     (addr),
    .from_cpu (from_cpu),
    .to_cpu   (to_cpu),
    .irq      (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All bus tasks start and end at a falling edge; cyc then names the edge just used.
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    ce = 1'b1; wren = 1'b1; addr = a; from_cpu = d;
    @(negedge clk);
    ce = 1'b0; wren = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    ce = 1'b1; wren = 1'b0; addr = a;
    @(negedge clk);
    ce = 1'b0;
    d = to_cpu;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Counter value after `t` edges of a run started with prescale p, reload r.
  function automatic int model_count(input int t, input int p, input int r, input bit per);
    int n;
    n = t / (p + 1);
    if (per) return r - (n % (r + 1));
    return (n >= r) ? 0 : r - n;
  endfunction

  task automatic test_reset();
    logic [15:0] d;
    logic [15:0] exp_v [4];
    exp_v[0] = 16'h0000; exp_v[1] = 16'hFFFF; exp_v[2] = 16'h0000; exp_v[3] = 16'h0000;
    rst = 1'b1; ce = 1'b0; wren = 1'b0; addr = 2'd0; from_cpu = '0;
    idle(3);
    rst = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || to_cpu !== 16'h0) begin
      n_fail++; $display("FAIL reset_out: irq=%b to_cpu=%h required 0/0000", irq, to_cpu);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), d);
      n_checks++;
      if (d !== exp_v[i]) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h required %h", i, d, exp_v[i]);
      end
    end
    bus_read(A_REL, d);
    idle(2);
    n_checks++;
    if (to_cpu !== 16'hFFFF) begin
      n_fail++; $display("FAIL read_hold: to_cpu=%h required ffff", to_cpu);
    end
  endtask

  task automatic test_oneshot();
    logic [15:0] d, e;
    int w;
    bit ex;
    bus_write(A_PRE, 16'd0);
    bus_write(A_REL, 16'd3);
    bus_write(A_CTL, 16'h0005);
    w = cyc;
    for (int k = 0; k < 8; k++) begin
      bus_read(A_CTL, d);
      ex = (cyc - 1 - w) >= 4;
      e  = {ex, 12'b0, 1'b1, 1'b0, ~ex};
      n_checks++;
      if (d !== e) begin
        n_fail++; $display("FAIL oneshot_ctl@%0d: got %h required %h", cyc - w, d, e);
      end
      n_checks++;
      if (irq !== ((cyc - 1 - w) >= 4)) begin
        n_fail++; $display("FAIL oneshot_irq@%0d: got %b required %b", cyc - w, irq, ~irq);
      end
    end
    bus_read(A_CNT, d);
    n_checks++;
    if (d !== 16'd0) begin
      n_fail++; $display("FAIL oneshot_count: got %h required 0000", d);
    end
    bus_write(A_CTL, 16'h8000);
    idle(2);
  endtask

  task automatic test_random_runs();
    logic [15:0] d;
    int p, r, w, t, per_len;
    bit per, ie;
    for (int it = 0; it < 6; it++) begin
      p   = int'($urandom_range(0, 3));
      r   = int'($urandom_range(0, 5));
      per = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      per_len = (p + 1) * (r + 1);
      bus_write(A_PRE, 16'(p));
      bus_write(A_REL, 16'(r));
      bus_write(A_CTL, {13'b0, ie, per, 1'b1});
      w = cyc;
      for (int s = 0; s < 40; s++) begin
        if ($urandom_range(0, 1) == 1) begin
          bus_read(A_CNT, d);
          t = cyc - 1 - w;
          n_checks++;
          if (d !== 16'(model_count(t, p, r, per))) begin
            n_fail++;
            $display("FAIL rand_count p=%0d r=%0d per=%0d t=%0d: got %0d required %0d",
                     p, r, per, t, d, model_count(t, p, r, per));
          end
        end else begin
          idle(1);
        end
        n_checks++;
        if (irq !== (ie && (cyc - 1 - w) >= per_len)) begin
          n_fail++;
          $display("FAIL rand_irq p=%0d r=%0d per=%0d ie=%0d t=%0d: got %b", p, r, per, ie,
                   cyc - w, irq);
        end
      end
      bus_write(A_CTL, 16'h8000);
      idle(1);
    end
  endtask

  task automatic test_clear_reassert();
    int w, c;
    bit exp_irq;
    bus_write(A_PRE, 16'd1);
    bus_write(A_REL, 16'd2);
    bus_write(A_CTL, 16'h0007);
    w = cyc;
    wait_until(w + 7);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL clr_first_irq: got %b required 1", irq);
    end
    bus_write(A_CTL, 16'h8007);
    c = cyc;
    for (int k = 0; k < 8; k++) begin
      // EXPIRED after edge x: set from w+6 until the clear, then from the next multiple of 6.
      exp_irq = ((cyc - 1) < c) ? ((cyc - 1) >= w + 6) : ((cyc - 1) >= w + 12);
      n_checks++;
      if (irq !== exp_irq) begin
        n_fail++; $display("FAIL clr_irq@%0d: got %b required %b", cyc - w, irq, exp_irq);
      end
      idle(1);
    end
    bus_write(A_CTL, 16'h8000);
    idle(1);
  endtask

  task automatic test_simultaneous();
    logic [15:0] d;
    int w;
    bus_write(A_PRE, 16'd0);
    bus_write(A_REL, 16'd2);
    bus_write(A_CTL, 16'h0003);
    w = cyc;
    wait_until(w + 5);
    bus_write(A_CTL, 16'h8003);
    bus_read(A_CTL, d);
    n_checks++;
    if (d !== 16'h8003) begin
      n_fail++; $display("FAIL clear_on_expiry: got %h required 8003", d);
    end
    bus_write(A_CTL, 16'h8003);
    bus_read(A_CTL, d);
    n_checks++;
    if (d !== 16'h0003) begin
      n_fail++; $display("FAIL clear_off_expiry: got %h required 0003", d);
    end
    bus_write(A_CTL, 16'h8000);

    bus_write(A_CTL, 16'h0001);
    w = cyc;
    wait_until(w + 2);
    bus_write(A_CTL, 16'h0001);
    bus_read(A_CNT, d);
    n_checks++;
    if (d !== 16'd2) begin
      n_fail++; $display("FAIL en_on_expiry_count: got %h required 0002", d);
    end
    bus_read(A_CTL, d);
    n_checks++;
    if (d !== 16'h8001) begin
      n_fail++; $display("FAIL en_on_expiry_ctl: got %h required 8001", d);
    end
    bus_write(A_CTL, 16'h8000);
    idle(1);
  endtask

  task automatic test_stop_hold();
    logic [15:0] d, e;
    int w, s;
    bus_write(A_PRE, 16'd0);
    bus_write(A_REL, 16'd9);
    bus_write(A_CTL, 16'h0007);
    w = cyc;
    wait_until(w + 12);
    bus_write(A_CTL, 16'h0006);
    s = cyc;
    e = 16'(model_count(s - 1 - w, 0, 9, 1'b1));
    bus_read(A_CNT, d);
    n_checks++;
    if (d !== e) begin
      n_fail++; $display("FAIL stop_count: got %0d required %0d", d, e);
    end
    for (int k = 0; k < 20; k++) begin
      idle(1);
      n_checks++;
      if (irq !== 1'b1) begin
        n_fail++; $display("FAIL stop_irq_hold@%0d: got %b required 1", k, irq);
      end
    end
    bus_read(A_CNT, d);
    n_checks++;
    if (d !== e) begin
      n_fail++; $display("FAIL stop_count_frozen: got %0d required %0d", d, e);
    end
    bus_write(A_CTL, 16'h0002);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irqen_off_same: got %b required 1", irq);
    end
    idle(1);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irqen_off_next: got %b required 0", irq);
    end
    bus_write(A_CTL, 16'h8000);
    idle(1);
  endtask

  task automatic test_reset_midrun();
    logic [15:0] d;
    logic [15:0] exp_v [4];
    int w;
    exp_v[0] = 16'h0000; exp_v[1] = 16'hFFFF; exp_v[2] = 16'h0000; exp_v[3] = 16'h0000;
    bus_write(A_PRE, 16'd3);
    bus_write(A_REL, 16'd1);
    bus_write(A_CTL, 16'h0007);
    w = cyc;
    wait_until(w + 9);
    bus_read(A_REL, d);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL midrun_pre_irq: got %b required 1", irq);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (irq !== 1'b0 || to_cpu !== 16'h0) begin
      n_fail++; $display("FAIL midrun_rst_out: irq=%b to_cpu=%h required 0/0000", irq, to_cpu);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), d);
      n_checks++;
      if (d !== exp_v[i]) begin
        n_fail++; $display("FAIL midrun_reg%0d: got %h required %h", i, d, exp_v[i]);
      end
    end
    idle(10);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL midrun_stays_idle: irq=%b required 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_random_runs();
    test_clear_reassert();
    test_simultaneous();
    test_stop_hold();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
